// File: rtl/switch_debounce3.sv
// switch_debounce3: input conditioning for the lamp logic (L = D & ~X | A).
// Three independent channels (door d, key x, override a). Each channel has a
// two-flop synchroniser, a stability counter and a registered output.
// An output follows its synchronised input only after DEBOUNCE_CYCLES
// consecutive mismatching cycles. A one-cycle chg pulse marks each accepted
// change. Bit order on every 3-bit vector is {d, x, a}.
// Optional feature, macro SWITCH_DEBOUNCE3_EDGE_EN: adds registered rise/fall
// outputs that split chg by the direction of the change.

module switch_debounce3 #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_raw,
  input  logic       x_raw,
  input  logic       a_raw,
  output logic       d,
  output logic       x,
  output logic       a,
  output logic [2:0] chg
`ifdef SWITCH_DEBOUNCE3_EDGE_EN
  ,
  output logic [2:0] rise,
  output logic [2:0] fall
`endif
);

  // Terminal count. When DEBOUNCE_CYCLES equals 2^CNT_W, the cast yields
  // all ones, which is still the correct last value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       raw_vec;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       out_q;
  logic [2:0]       out_d;
  logic [2:0]       chg_q;
  logic [2:0]       chg_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  assign raw_vec = {d_raw, x_raw, a_raw};

  // Two-flop synchroniser for the three asynchronous switch inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce decision. Agreement clears the counter (STABLE).
  // Disagreement counts up (PENDING) until the terminal count, and the
  // output then takes the new level.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      out_d[i] = out_q[i];
      chg_d[i] = 1'b0;
      cnt_d[i] = '0;
      if (sync2_q[i] != out_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          out_d[i] = sync2_q[i];
          chg_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // State registers for the counters, debounced levels and change pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 3'b000;
      chg_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_q <= out_d;
      chg_q <= chg_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign d   = out_q[2];
  assign x   = out_q[1];
  assign a   = out_q[0];
  assign chg = chg_q;

`ifdef SWITCH_DEBOUNCE3_EDGE_EN
  logic [2:0] rise_q;
  logic [2:0] fall_q;

  // Direction-qualified change pulses, aligned with chg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 3'b000;
      fall_q <= 3'b000;
    end else begin
      rise_q <= chg_d & out_d;
      fall_q <= chg_d & ~out_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: tb/tb_switch_debounce3.sv
// tb_switch_debounce3: directed test of switch_debounce3.
// Main instance uses DEBOUNCE_CYCLES=4. A second instance uses
// DEBOUNCE_CYCLES=1 and shares the same inputs for the minimum-latency case.
// Inputs are driven 1 ns after a rising edge, so the next rising edge is
// "edge 1". Outputs are sampled 1 ns after each edge.

module tb_switch_debounce3;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_raw;
  logic       x_raw;
  logic       a_raw;
  logic       d;
  logic       x;
  logic       a;
  logic [2:0] chg;
  logic       d1;
  logic       x1;
  logic       a1;
  logic [2:0] chg1;
`ifdef SWITCH_DEBOUNCE3_EDGE_EN
  logic [2:0] rise;
  logic [2:0] fall;
  logic [2:0] rise1;
  logic [2:0] fall1;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  switch_debounce3 #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .d_raw(d_raw), .x_raw(x_raw), .a_raw(a_raw),
    .d(d), .x(x), .a(a), .chg(chg)
`ifdef SWITCH_DEBOUNCE3_EDGE_EN
    , .rise(rise), .fall(fall)
`endif
  );

  switch_debounce3 #(.DEBOUNCE_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .d_raw(d_raw), .x_raw(x_raw), .a_raw(a_raw),
    .d(d1), .x(x1), .a(a1), .chg(chg1)
`ifdef SWITCH_DEBOUNCE3_EDGE_EN
    , .rise(rise1), .fall(fall1)
`endif
  );

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d_raw = 1'b0; x_raw = 1'b0; a_raw = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      testsRun++;
      if ({d, x, a, chg} !== 6'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset.in_reset edge %0d: got dxa=%b%b%b chg=%b, expected all 0", k, d, x, a, chg);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      testsRun++;
      if ({d, x, a, chg, d1, x1, a1, chg1} !== 12'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset.idle edge %0d: got dxa=%b%b%b chg=%b dxa1=%b%b%b chg1=%b, expected all 0",
                 k, d, x, a, chg, d1, x1, a1, chg1);
      end
    end
  endtask

  task automatic test_single_d();
    logic       expD;
    logic [2:0] expChg;
    logic       expD1;
    logic [2:0] expChg1;
    d_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expD    = (k >= 6);
      expChg  = (k == 6) ? 3'b100 : 3'b000;
      expD1   = (k >= 3);
      expChg1 = (k == 3) ? 3'b100 : 3'b000;
      testsRun++;
      if (d !== expD) begin
        testsFailed++;
        $display("[TB] FAIL single_d.rise.d edge %0d: got %b expected %b", k, d, expD);
      end
      testsRun++;
      if (chg !== expChg) begin
        testsFailed++;
        $display("[TB] FAIL single_d.rise.chg edge %0d: got %b expected %b", k, chg, expChg);
      end
      testsRun++;
      if ({x, a} !== 2'b00) begin
        testsFailed++;
        $display("[TB] FAIL single_d.rise.xa edge %0d: got %b%b expected 00", k, x, a);
      end
      testsRun++;
      if ({d1, chg1} !== {expD1, expChg1}) begin
        testsFailed++;
        $display("[TB] FAIL single_d.rise.min_latency edge %0d: got d1=%b chg1=%b expected d1=%b chg1=%b",
                 k, d1, chg1, expD1, expChg1);
      end
    end
    d_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expD    = (k < 6);
      expChg  = (k == 6) ? 3'b100 : 3'b000;
      expD1   = (k < 3);
      expChg1 = (k == 3) ? 3'b100 : 3'b000;
      testsRun++;
      if ({d, chg} !== {expD, expChg}) begin
        testsFailed++;
        $display("[TB] FAIL single_d.fall edge %0d: got d=%b chg=%b expected d=%b chg=%b",
                 k, d, chg, expD, expChg);
      end
      testsRun++;
      if ({d1, chg1} !== {expD1, expChg1}) begin
        testsFailed++;
        $display("[TB] FAIL single_d.fall.min_latency edge %0d: got d1=%b chg1=%b expected d1=%b chg1=%b",
                 k, d1, chg1, expD1, expChg1);
      end
    end
  endtask

  task automatic test_bounce();
    logic       bouncePattern [5];
    logic       expX;
    logic [2:0] expChg;
    bouncePattern = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    // The last 1 is first sampled at edge 5, so x rises at edge 5+5 = 10.
    for (int k = 1; k <= 12; k++) begin
      x_raw = (k <= 5) ? bouncePattern[k-1] : 1'b1;
      tick();
      expX   = (k >= 10);
      expChg = (k == 10) ? 3'b010 : 3'b000;
      testsRun++;
      if ({x, chg} !== {expX, expChg}) begin
        testsFailed++;
        $display("[TB] FAIL bounce.x edge %0d: got x=%b chg=%b expected x=%b chg=%b",
                 k, x, chg, expX, expChg);
      end
    end
    x_raw = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    testsRun++;
    if ({x, chg} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL bounce.restore: got x=%b chg=%b expected x=0 chg=000", x, chg);
    end
  endtask

  task automatic test_simultaneous();
    logic       expDA;
    logic [2:0] expChg;
    logic       lamp;
    d_raw = 1'b1; a_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expDA  = (k >= 6);
      expChg = (k == 6) ? 3'b101 : 3'b000;
      lamp   = (d & ~x) | a;
      testsRun++;
      if ({d, x, a, chg} !== {expDA, 1'b0, expDA, expChg}) begin
        testsFailed++;
        $display("[TB] FAIL simultaneous edge %0d: got dxa=%b%b%b chg=%b expected dxa=%b0%b chg=%b",
                 k, d, x, a, chg, expDA, expDA, expChg);
      end
      testsRun++;
      if (lamp !== expDA) begin
        testsFailed++;
        $display("[TB] FAIL simultaneous.lamp edge %0d: got %b expected %b", k, lamp, expDA);
      end
    end
    d_raw = 1'b0; a_raw = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    testsRun++;
    if ({d, x, a} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL simultaneous.restore: got dxa=%b%b%b expected 000", d, x, a);
    end
  endtask

  task automatic test_reset_mid();
    logic       expA;
    logic [2:0] expChg;
    a_raw = 1'b1;
    // Edges 3 and 4 are the first two PENDING cycles.
    for (int k = 1; k <= 4; k++) tick();
    rst = 1'b1;
    #1;
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) tick();
      testsRun++;
      if ({a, chg} !== 4'b0000) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid.in_reset step %0d: got a=%b chg=%b expected a=0 chg=000", k, a, chg);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expA   = (k >= 6);
      expChg = (k == 6) ? 3'b001 : 3'b000;
      testsRun++;
      if ({a, chg} !== {expA, expChg}) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid.after edge %0d: got a=%b chg=%b expected a=%b chg=%b",
                 k, a, chg, expA, expChg);
      end
    end
    a_raw = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    testsRun++;
    if (a !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid.restore: got a=%b expected 0", a);
    end
  endtask

`ifdef SWITCH_DEBOUNCE3_EDGE_EN
  task automatic test_edge();
    logic [2:0] expRise;
    logic [2:0] expFall;
    d_raw = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      expRise = (k == 6) ? 3'b100 : 3'b000;
      testsRun++;
      if ({rise, fall} !== {expRise, 3'b000}) begin
        testsFailed++;
        $display("[TB] FAIL edge.rise edge %0d: got rise=%b fall=%b expected rise=%b fall=000",
                 k, rise, fall, expRise);
      end
    end
    d_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expFall = (k == 6) ? 3'b100 : 3'b000;
      testsRun++;
      if ({rise, fall} !== {3'b000, expFall}) begin
        testsFailed++;
        $display("[TB] FAIL edge.fall edge %0d: got rise=%b fall=%b expected rise=000 fall=%b",
                 k, rise, fall, expFall);
      end
      testsRun++;
      if ((rise & fall) !== 3'b000) begin
        testsFailed++;
        $display("[TB] FAIL edge.exclusive edge %0d: got rise&fall=%b expected 000", k, rise & fall);
      end
    end
  endtask
`endif

  // Run every scenario in sequence, then report.
  initial begin
    rst = 1'b1; d_raw = 1'b0; x_raw = 1'b0; a_raw = 1'b0;
    #1;
    test_reset();
    test_single_d();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
`ifdef SWITCH_DEBOUNCE3_EDGE_EN
    test_edge();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/switch_debounce3.md
Name: switch_debounce3

Overview:
- Input-conditioning stage for the lamp-logic block (L = D & ~X | A). Sits directly upstream of it.
- Takes three raw, asynchronous switch inputs (door D, key X, override A) and synchronises each to clk.
- Debounces each input independently and delivers clean, stable d/x/a levels plus per-channel change pulses.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive synchronised cycles an input must differ from the current output before the output follows (1 ms at 50 MHz); legal range 1..2^CNT_W.
- CNT_W, 16, width of each per-channel stability counter.

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
d_raw  input  1  raw door switch, asynchronous, may bounce
x_raw  input  1  raw key switch, asynchronous, may bounce
a_raw  input  1  raw override switch, asynchronous, may bounce
d  output  1  debounced door level to lamp logic
x  output  1  debounced key level to lamp logic
a  output  1  debounced override level to lamp logic
chg  output  3  one-cycle pulse when the debounced level changes; bit2=d, bit1=x, bit0=a

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst=1, all sync flops, counters, d/x/a and chg are 0.
- Three identical, independent channels. Each channel has:
  - 2-flop synchroniser s1 <= raw, s2 <= s1.
  - CNT_W-bit counter cnt.
  - Registered output out.
- Per rising edge, per channel:
  - If s2 == out: cnt <= 0, chg bit <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: out <= s2, cnt <= 0, chg bit <= 1.
  - Else: cnt <= cnt+1, chg bit <= 0.
- Effective states per channel: STABLE (s2 == out, cnt=0) and PENDING (s2 != out, counting). A mismatch moves STABLE to PENDING. PENDING returns to STABLE on a bounce back (cnt cleared, no output change) or on count completion (output updated).
- Latency: a clean raw transition first sampled by s1 at edge 1 appears on out at edge DEBOUNCE_CYCLES+2. chg is high for exactly the cycle following that edge. With DEBOUNCE_CYCLES=1, out changes at edge 3.
- Bounce: any return of s2 to out before completion restarts the count from 0. The required stable run is always a full DEBOUNCE_CYCLES consecutive mismatching cycles.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Simultaneous changes on several channels are handled independently. Multiple chg bits may assert in the same cycle.
- Reset mid-count: the pending change is discarded and out=0. If a raw input is held 1 through reset release, out rises at edge DEBOUNCE_CYCLES+2 counted from the first edge after release.
- Outputs are purely registered; there is no combinational path from raw inputs to outputs.

Optional Feature:
- Macro: SWITCH_DEBOUNCE3_EDGE_EN.
- Defined: adds output ports rise (3 bits) and fall (3 bits), same bit order as chg.
  - rise bit = chg bit AND new out = 1; fall bit = chg bit AND new out = 0.
  - Registered, same cycle as chg, reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, raw all 0, release -> d=x=a=0 and chg=000 for 20 cycles.
- DEBOUNCE_CYCLES=4. d_raw 0->1 sampled at edge 1, held -> d=1 after edge 6; chg=100 for exactly one cycle; x and a unchanged.
- DEBOUNCE_CYCLES=4. x_raw bounces 1,0,1,0,1 one cycle each, then held 1 -> x stays 0 during the bounce; x=1 only after 4 consecutive synchronised 1s; single chg=010 pulse.
- DEBOUNCE_CYCLES=4. d_raw and a_raw rise on the same edge -> d and a rise on the same edge; chg=101 for one cycle. Downstream lamp L=1 (A=1).
- DEBOUNCE_CYCLES=4. a_raw held 1, rst pulsed after 2 cycles of PENDING -> a=0 during reset; a=1 at edge 6 after release; no chg during reset.
- With SWITCH_DEBOUNCE3_EDGE_EN: d rises then, after 10 cycles, d_raw falls -> rise=100 on the rising pulse, fall=100 on the falling pulse; never both set in the same cycle.
